rr_req_frontend: RTL and testbench
==================================

// Module: rr_req_frontend
// PURPOSE
//  Upstream stage of rr_arbiter. Buffers one transaction per client in a
//  single-entry slot, drives req[i] while slot i holds data, and consumes the
//  arbiter's one-hot gnt. Moves the granted slot into one registered output
//  stage (valid/ready) tagged with the client id. Flags protocol errors on gnt.
// PARAMETERS
//  N   4   number of clients; must match the arbiter's N (N>=2)
//  DW  32  payload width per client
// PORTS
//  clk        in   1          clock, rising edge
//  rstn       in   1          reset, asynchronous, active-low
//  in_valid   in   N          per-client transaction valid
//  in_data    in   N*DW       per-client payload, client i at [i*DW +: DW]
//  in_ready   out  N          per-client slot can accept
//  req        out  N          request vector to the arbiter
//  gnt        in   N          grant vector from the arbiter (comb, one-hot or 0)
//  out_valid  out  1          output stage holds a transaction
//  out_data   out  DW         payload of held transaction
//  out_id     out  $clog2(N)  client index of held transaction
//  out_ready  in   1          downstream accepts; transfer = out_valid&out_ready
//  err_gnt    out  1          sticky gnt protocol error
// BEHAVIOUR
//  Reset (async, rstn=0): slot_full=0, req=0, in_ready=all 1, out_valid=0,
//   out_data=0, out_id=0, err_gnt=0. Outputs are valid immediately in reset.
//  Per-client slot, 2 states: EMPTY / FULL.
//   EMPTY: in_ready[i]=1; in_valid[i] captures in_data slice -> FULL next edge.
//   FULL:  in_ready[i]=0; req[i]=1 (req == slot_full, registered, no comb path
//          from in_valid). Leave FULL only on pop[i].
//  out_free = !out_valid | out_ready.
//  pop[i] = gnt[i] & slot_full[i] & out_free. At most one pop per cycle.
//   On pop: out_data<=slot i data, out_id<=i, out_valid<=1, slot i -> EMPTY.
//   No pop while !out_free: gnt may stay high with req held (the arbiter keeps the
//   grant while req is high). The slot waits without loss.
//  No same-cycle refill. in_ready[i] depends only on slot_full[i], so a popped
//   slot is EMPTY for at least 1 cycle. req[i] then drops for >=1 cycle, which
//   lets the arbiter rotate its token. This is required for fairness.
//  Output stage: if out_valid & out_ready & no pop -> out_valid<=0. If pop in the
//   same cycle, load the new entry (back-to-back, no bubble). out_data and out_id
//   hold stable while out_valid & !out_ready.
//  Latency: in_valid accept at edge T -> req[i]=1 after T. Fastest out_valid=1
//   after edge T+1 (token already on i, out_free). Worst case adds token rotation.
//  err_gnt (sticky until reset) sets on either condition:
//   - gnt not one-hot and not zero (popcount>1);
//   - gnt[i]=1 while slot_full[i]=0.
//   On error: pop only the lowest-index valid gnt&slot_full bit; ignore the rest.
//  Reset mid-operation: all slot and output contents are discarded and no
//   transfer completes. Upstream must re-send.
//  Width rules: out_id = index of the popped bit (priority encoder, lowest index
//   first). For non-power-of-2 N, ids >= N never appear.
// TESTING
//  1 Reset: rstn=0 mid-traffic -> req=0, out_valid=0, in_ready=4'b1111,
//    err_gnt=0 in the same cycle.
//  2 Single client: in_valid[2]=1, data=32'hA5A5_0002, arbiter token at 2 ->
//    req=4'b0100 next cycle, then out_valid=1, out_id=2, data A5A5_0002.
//    in_ready[2] returns to 1 the cycle after pop.
//  3 All 4 clients load together, out_ready=1 -> out_id sequence 0,1,2,3
//    (from arbiter rotation). Each req[i] drops exactly once before reload.
//  4 Backpressure: out_ready=0 for 5 cycles with out_valid=1 and slot 1 granted ->
//    out_data/out_id stable, req[1] stays 1, no pop. out_ready=1 -> slot 1 pops
//    in the same cycle the old entry drains (no bubble).
//  5 Client 0 re-presents in_valid continuously -> its req has a >=1-cycle gap
//    after every pop. Clients 1..3, also full, are each served within 4 pops.
//  6 Force gnt=4'b0011, and separately gnt=4'b1000 with slot 3 empty ->
//    err_gnt=1 and sticky. First case pops only client 0. Second case: no pop.

Source files
------------

// File: rtl/rr_req_frontend.sv
// rr_req_frontend: one single-entry slot per client feeding a round-robin arbiter,
// a registered valid/ready output stage tagged with client id, and a sticky gnt error.
module rr_req_frontend #(
  parameter int N  = 4,
  parameter int DW = 32,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [N-1:0]    in_valid,
  input  logic [N*DW-1:0] in_data,
  output logic [N-1:0]    in_ready,
  output logic [N-1:0]    req,
  input  logic [N-1:0]    gnt,
  output logic            out_valid,
  output logic [DW-1:0]   out_data,
  output logic [IW-1:0]   out_id,
  input  logic            out_ready,
  output logic            err_gnt
);

  typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} slot_st_e;

  localparam logic [N-1:0] ONE_N = N'(1);

  // Keeps only the lowest set bit, so a malformed gnt can never pop two slots.
  function automatic logic [N-1:0] lowest_one(input logic [N-1:0] v);
    return v & (~v + ONE_N);
  endfunction

  function automatic logic [IW-1:0] onehot_idx(input logic [N-1:0] v);
    logic [IW-1:0] r;
    r = '0;
    for (int k = N - 1; k >= 0; k--) begin
      r = v[k] ? IW'(k) : r;
    end
    return r;
  endfunction

  slot_st_e          slot_q [N];
  slot_st_e          slot_d [N];
  logic [DW-1:0]     data_q [N];
  logic [DW-1:0]     data_d [N];
  logic              out_valid_q, out_valid_d;
  logic [DW-1:0]     out_data_q, out_data_d;
  logic [IW-1:0]     out_id_q, out_id_d;
  logic              err_q, err_d;

  logic [N-1:0]      slot_full_s;
  logic              out_free_s;
  logic [N-1:0]      pop_s;
  logic [IW-1:0]     pop_idx_s;
  logic              gnt_multi_s;
  logic              gnt_stray_s;

  // Slot occupancy vector and the pop decision.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      slot_full_s[i] = (slot_q[i] == S_FULL);
    end
    out_free_s  = !out_valid_q || out_ready;
    pop_s       = out_free_s ? lowest_one(gnt & slot_full_s) : '0;
    pop_idx_s   = onehot_idx(pop_s);
    gnt_multi_s = ((gnt & (gnt - ONE_N)) != '0);
    gnt_stray_s = ((gnt & ~slot_full_s) != '0);
  end

  // Per-slot EMPTY/FULL next state; a popped slot cannot refill in the same cycle.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      slot_d[i] = slot_q[i];
      data_d[i] = data_q[i];
      case (slot_q[i])
        S_EMPTY: begin
          if (in_valid[i]) begin
            slot_d[i] = S_FULL;
            data_d[i] = in_data[i*DW +: DW];
          end else begin
            slot_d[i] = S_EMPTY;
          end
        end
        S_FULL: begin
          if (pop_s[i]) begin
            slot_d[i] = S_EMPTY;
          end else begin
            slot_d[i] = S_FULL;
          end
        end
        default: slot_d[i] = S_EMPTY;
      endcase
    end
  end

  // Output stage: a pop reloads even while draining, so there is no bubble.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    if (pop_s != '0) begin
      out_valid_d = 1'b1;
      out_data_d  = data_q[pop_idx_s];
      out_id_d    = pop_idx_s;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
    err_d = err_q || gnt_multi_s || gnt_stray_s;
  end

  // State registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < N; i++) begin
        slot_q[i] <= S_EMPTY;
        data_q[i] <= '0;
      end
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        slot_q[i] <= slot_d[i];
        data_q[i] <= data_d[i];
      end
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      err_q       <= err_d;
    end
  end

  assign in_ready  = ~slot_full_s;
  assign req       = slot_full_s;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;
  assign err_gnt   = err_q;

endmodule

// File: tb/tb_rr_req_frontend.sv
// Directed bench for rr_req_frontend; a small round-robin arbiter model supplies gnt
// and can be overridden to inject protocol errors.
module tb_rr_req_frontend;

  localparam int N  = 4;
  localparam int DW = 32;

  logic            clk;
  logic            rstn;
  logic [N-1:0]    in_valid;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]    in_ready;
  logic [N-1:0]    req;
  logic [N-1:0]    gnt;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [1:0]      out_id;
  logic            out_ready;
  logic            err_gnt;

  logic [N-1:0]    arb_gnt;
  logic [1:0]      arb_idx;
  logic [1:0]      arb_ptr;
  logic [1:0]      arb_j;
  logic            arb_found;
  logic            ptr_ld;
  logic [1:0]      ptr_ld_val;
  logic            force_en;
  logic [N-1:0]    force_gnt;

  int n_checks;
  int n_errors;

  rr_req_frontend #(.N(N), .DW(DW)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .req       (req),
    .gnt       (gnt),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_ready (out_ready),
    .err_gnt   (err_gnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Arbiter model: grant the first requester at or after the token; token follows the grant.
  always_comb begin
    arb_gnt   = '0;
    arb_idx   = 2'd0;
    arb_found = 1'b0;
    arb_j     = 2'd0;
    for (int k = 0; k < N; k++) begin
      arb_j = arb_ptr + 2'(k);
      if (!arb_found && req[arb_j]) begin
        arb_gnt[arb_j] = 1'b1;
        arb_idx        = arb_j;
        arb_found      = 1'b1;
      end
    end
  end

  assign gnt = force_en ? force_gnt : arb_gnt;

  always @(posedge clk) begin
    if (ptr_ld) arb_ptr <= ptr_ld_val;
    else if (arb_found && !force_en) arb_ptr <= arb_idx;
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] pat(input int i);
    return 32'hC0DE_0000 + DW'(i);
  endfunction

  // Present mask for one edge with the standard per-client patterns, token at ptr.
  task automatic load(input logic [N-1:0] mask, input logic [1:0] ptr);
    for (int i = 0; i < N; i++) in_data[i*DW +: DW] = pat(i);
    in_valid   = mask;
    ptr_ld     = 1'b1;
    ptr_ld_val = ptr;
    step();
    in_valid = '0;
    ptr_ld   = 1'b0;
  endtask

  logic [1:0]   t5_id    [7];
  logic [N-1:0] t5_req   [7];
  logic         t5_valid [7];

  initial begin
    n_checks = 0; n_errors = 0;
    rstn = 1'b0; in_valid = '0; in_data = '0; out_ready = 1'b0;
    force_en = 1'b0; force_gnt = '0; ptr_ld = 1'b1; ptr_ld_val = 2'd0;
    step();
    chk("rst_req", 64'(req), 64'h0);
    chk("rst_in_ready", 64'(in_ready), 64'hF);
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_out_data", 64'(out_data), 64'h0);
    chk("rst_err", 64'(err_gnt), 64'h0);
    rstn = 1'b1; ptr_ld = 1'b0;
    step();

    // Single client 2 with token at 2
    in_data[2*DW +: DW] = 32'hA5A5_0002;
    in_valid = 4'b0100; ptr_ld = 1'b1; ptr_ld_val = 2'd2;
    step();
    in_valid = '0; ptr_ld = 1'b0;
    chk("t2_req", 64'(req), 64'h4);
    chk("t2_in_ready", 64'(in_ready), 64'hB);
    chk("t2_valid_before", 64'(out_valid), 64'h0);
    step();
    chk("t2_out_valid", 64'(out_valid), 64'h1);
    chk("t2_out_id", 64'(out_id), 64'h2);
    chk("t2_out_data", 64'(out_data), 64'hA5A5_0002);
    chk("t2_in_ready_back", 64'(in_ready), 64'hF);
    chk("t2_req_drop", 64'(req), 64'h0);
    out_ready = 1'b1;
    step();
    chk("t2_drain", 64'(out_valid), 64'h0);

    // Reset mid-traffic: slot 3 waiting, output stage holding client 0
    out_ready = 1'b0;
    load(4'b1001, 2'd0);
    step();
    chk("t1_pre_valid", 64'(out_valid), 64'h1);
    chk("t1_pre_req", 64'(req), 64'h8);
    rstn = 1'b0;
    #1;
    chk("t1_req", 64'(req), 64'h0);
    chk("t1_out_valid", 64'(out_valid), 64'h0);
    chk("t1_in_ready", 64'(in_ready), 64'hF);
    chk("t1_err", 64'(err_gnt), 64'h0);
    chk("t1_out_id", 64'(out_id), 64'h0);
    step();
    rstn = 1'b1;
    step();

    // All four load together, token at 0, no backpressure
    out_ready = 1'b1;
    load(4'b1111, 2'd0);
    chk("t3_req_all", 64'(req), 64'hF);
    chk("t3_valid0", 64'(out_valid), 64'h0);
    for (int k = 0; k < N; k++) begin
      step();
      chk($sformatf("t3_valid_%0d", k), 64'(out_valid), 64'h1);
      chk($sformatf("t3_id_%0d", k), 64'(out_id), 64'(k));
      chk($sformatf("t3_data_%0d", k), 64'(out_data), 64'(pat(k)));
      chk($sformatf("t3_req_%0d", k), 64'(req), 64'((4'hF << (k + 1)) & 4'hF));
    end
    step();
    chk("t3_drain", 64'(out_valid), 64'h0);

    // Backpressure with slot 1 granted behind a held entry
    out_ready = 1'b0;
    load(4'b0011, 2'd0);
    step();
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("t4_valid_%0d", c), 64'(out_valid), 64'h1);
      chk($sformatf("t4_id_%0d", c), 64'(out_id), 64'h0);
      chk($sformatf("t4_data_%0d", c), 64'(out_data), 64'(pat(0)));
      chk($sformatf("t4_req_%0d", c), 64'(req), 64'h2);
      chk($sformatf("t4_gnt_%0d", c), 64'(gnt), 64'h2);
      step();
    end
    out_ready = 1'b1;
    step();
    chk("t4_b2b_valid", 64'(out_valid), 64'h1);
    chk("t4_b2b_id", 64'(out_id), 64'h1);
    chk("t4_b2b_data", 64'(out_data), 64'(pat(1)));
    chk("t4_b2b_req", 64'(req), 64'h0);
    step();
    chk("t4_drain", 64'(out_valid), 64'h0);

    // Client 0 re-presents continuously while 1..3 wait
    t5_id    = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0};
    t5_req   = '{4'b1110, 4'b1101, 4'b1001, 4'b0001, 4'b0000, 4'b0001, 4'b0000};
    t5_valid = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    load(4'b1111, 2'd0);
    in_valid = 4'b0001;
    for (int e = 0; e < 7; e++) begin
      step();
      chk($sformatf("t5_valid_%0d", e), 64'(out_valid), 64'(t5_valid[e]));
      if (t5_valid[e]) chk($sformatf("t5_id_%0d", e), 64'(out_id), 64'(t5_id[e]));
      chk($sformatf("t5_req_%0d", e), 64'(req), 64'(t5_req[e]));
    end
    in_valid = '0;
    step();
    chk("t5_drain", 64'(out_valid), 64'h0);

    // Multi-hot grant pops only the lowest index
    force_en = 1'b1; force_gnt = '0;
    load(4'b0011, 2'd0);
    chk("t6a_req", 64'(req), 64'h3);
    force_gnt = 4'b0011;
    step();
    chk("t6a_err", 64'(err_gnt), 64'h1);
    chk("t6a_valid", 64'(out_valid), 64'h1);
    chk("t6a_id", 64'(out_id), 64'h0);
    chk("t6a_req_after", 64'(req), 64'h2);
    force_gnt = '0;
    step();
    chk("t6a_sticky", 64'(err_gnt), 64'h1);
    chk("t6a_no_extra", 64'(out_valid), 64'h0);
    chk("t6a_slot1_kept", 64'(req), 64'h2);

    // Grant to an empty slot: error, no pop
    rstn = 1'b0;
    #1;
    chk("t6_rst_err", 64'(err_gnt), 64'h0);
    step();
    rstn = 1'b1;
    step();
    load(4'b0010, 2'd0);
    force_gnt = 4'b1000;
    step();
    chk("t6b_err", 64'(err_gnt), 64'h1);
    chk("t6b_no_pop", 64'(out_valid), 64'h0);
    chk("t6b_req", 64'(req), 64'h2);
    force_gnt = '0;
    step();
    chk("t6b_sticky", 64'(err_gnt), 64'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
